adc_phase_cal: RTL and testbench
================================

# adc_phase_cal

Sequencer for the KAT ADC interface MMCM dynamic phase shift. On command it:
- sweeps the capture clock phase across a fixed number of MMCM steps, qualifying each position with the ADC's data-check flag;
- finds the longest contiguous good window;
- parks the phase at the window centre.

It sits between the ADC SPI/config register block (start, results) and the MMCM `mmcm_psen`/`mmcm_psincdec`/`mmcm_psdone` port, replacing manual software stepping.

## Interface
- `STEPS`, default 448: phase positions evaluated, 0..STEPS-1. Minimum 2.
- `SETTLE`, default 64: cycles waited after `psdone` before sampling.
- `SAMPLES`, default 256: cycles `data_ok` is sampled per position.
- `TIMEOUT`, default 1024: maximum cycles from `psen` to `psdone`.
- `CW`, default 10: width of position/length fields. Must satisfy 2^CW > STEPS.

Ports:
- `wb_clk_i`  in  1  single clock; also drives the MMCM `psclk` externally.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a calibration.
- `mmcm_locked`  in  1  MMCM lock, already synchronous to `wb_clk_i`.
- `data_ok`  in  1  ADC pattern/validity flag, already synchronous to `wb_clk_i`.
- `mmcm_psdone`  in  1  MMCM phase-step completion pulse.
- `mmcm_psen`  out  1  phase-step enable pulse.
- `mmcm_psincdec`  out  1  1 = increment, 0 = decrement.
- `busy`  out  1  calibration in progress.
- `done`  out  1  one-cycle pulse at completion, success or error.
- `error`  out  1  last run failed; sticky until the next accepted `start`.
- `win_start`  out  CW  first position of the chosen window.
- `win_len`  out  CW  length of the chosen window; 0 = none found.
- `phase`  out  CW  current position relative to the start of the run.

## Operation
- States: IDLE, SETTLE, SAMPLE, EVAL, STEP, STEP_WAIT, CENTER, CENTER_WAIT, FINISH.
- **IDLE**
  - `start` with `mmcm_locked`=1: clear `error`, `win_*`, `phase`, run trackers; go to SETTLE.
  - `start` with `mmcm_locked`=0: set `error`, pulse `done`, stay in IDLE.
  - `start` while `busy` is ignored.
- **SETTLE**: count SETTLE cycles, then go to SAMPLE.
- **SAMPLE**: over SAMPLES cycles, the position is bad if `data_ok`=0 on any cycle.
- **EVAL**: update the run trackers.
  - Good position: extend the current run (`run_start` set on the first good position of the run).
  - Bad position: close the current run.
  - A run replaces the best window only if strictly longer. On equal length the earliest run wins.
  - A run still open at position STEPS-1 is closed in EVAL.
  - No wrap-around: runs at position 0 and STEPS-1 are never joined.
  - If `phase` < STEPS-1, go to STEP; otherwise go to CENTER.
- **STEP**: assert `mmcm_psen`=1, `mmcm_psincdec`=1; `phase` += 1; go to STEP_WAIT.
- **STEP_WAIT**: wait for `mmcm_psdone`, then go to SETTLE.
- **CENTER**: compute the target.
  - `win_len`>0: target = `win_start` + (`win_len` >> 1).
  - `win_len`=0: target = 0 and `error` is set.
  - Issue decrement steps (`mmcm_psincdec`=0) until `phase` == target. Each step goes via CENTER_WAIT, and `phase` -= 1 at each `psen`.
- **FINISH**: pulse `done`, return to IDLE.
- **Abort**: in any busy state, `mmcm_locked`=0, or a `psdone` timeout, sets `error`, pulses `done` and goes to IDLE. The MMCM is left where it is and `phase` reports that position.
- **Reset mid-operation**: return to IDLE immediately; any outstanding `psdone` is ignored.

## Timing
- Reset values: all outputs 0, state IDLE.
- `mmcm_psen` is exactly one cycle high. `mmcm_psincdec` is valid in the same cycle and held until `psdone`.
- No new `psen` is issued before `psdone` of the previous step.
- `psdone` counts only in the *_WAIT states.
- Timeout: `psdone` not seen within TIMEOUT cycles of `psen` triggers an abort in cycle TIMEOUT+1.
- `busy` rises the cycle after the accepted `start` and falls in the same cycle `done` pulses.
- `win_start`/`win_len` are final in the cycle `busy` falls and hold until the next accepted `start`.
- Scan cost per position: SETTLE + SAMPLES + 1 (EVAL) cycles, plus the `psdone` latency on each step.
- `mmcm_locked` must be stable for a run: a single cycle of `mmcm_locked`=0 during a run aborts it.

## Structure
- Shared package `adc_cal_pkg`: state encoding and the default STEPS/SETTLE/SAMPLES/TIMEOUT constants, reused by the software register map.
- One natural sub-module, `ps_stepper`: issues one `psen` per request, holds `psincdec`, runs the `psdone` timeout and reports done/timeout. It is used by both STEP and CENTER.
- Window tracking (`run_start`, `run_len`, best start, best len) stays in the top-level FSM.

## Test plan
- STEPS=16, SETTLE=4, SAMPLES=8, `data_ok` always 1, `psdone` 3 cycles after `psen` → 15 increments, `win_start`=0, `win_len`=16, 7 decrements, `phase`=8, `error`=0.
- Good only at positions 5..9 → `win_start`=5, `win_len`=5, final `phase`=7, 8 decrements.
- Good at 2..4 and 10..12 → earliest wins: `win_start`=2, `win_len`=3, final `phase`=3. Separately, good at 13..15 only → window closed at end: `win_start`=13, `win_len`=3.
- All positions bad → `win_len`=0, `error`=1, 15 decrements back to `phase`=0, one `done` pulse.
- `psdone` withheld after step 4 → abort after TIMEOUT cycles: `error`=1, `phase`=5, `done` pulses. `start` while `busy` has no effect.
- `mmcm_locked` dropped during SAMPLE → `error`=1 next cycle, IDLE. Reset asserted in STEP_WAIT → all outputs 0 next cycle; a late `psdone` is ignored.

Source files
------------

// File: rtl/adc_cal_pkg.sv
// adc_cal_pkg: state encoding and default sweep constants shared with the register map
package adc_cal_pkg;
  localparam int DEF_STEPS   = 448;
  localparam int DEF_SETTLE  = 64;
  localparam int DEF_SAMPLES = 256;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CW      = 10;
  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP, S_STEP_WAIT, S_CENTER, S_CENTER_WAIT, S_FINISH
  } state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ps_stepper.sv
// ps_stepper: one MMCM phase step per request with psdone timeout
module ps_stepper import adc_cal_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic dir,
  input  logic psdone,
  input  logic abort,
  output logic psen,
  output logic psincdec,
  output logic ack,
  output logic timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic pending;
  logic dir_r;
  logic [TW-1:0] tcnt;
  // tcnt holds k-1 in the k-th cycle after psen, so psdone is accepted through cycle TIMEOUT
  assign psen     = req;
  assign psincdec = req ? dir : dir_r;
  assign ack      = pending & psdone;
  assign timeout  = pending & ~psdone & (tcnt == TW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      dir_r   <= 1'b0;
      tcnt    <= '0;
    end else if (req) begin
      pending <= 1'b1;
      dir_r   <= dir;
      tcnt    <= '0;
    end else if (abort || ack || timeout) begin
      pending <= 1'b0;
    end else if (pending) begin
      tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_phase_cal.sv
// adc_phase_cal: sweeps MMCM capture phase, finds longest good window, parks at its centre
module adc_phase_cal import adc_cal_pkg::*; #(
  parameter int STEPS   = DEF_STEPS,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int SAMPLES = DEF_SAMPLES,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start,
  input  logic          mmcm_locked,
  input  logic          data_ok,
  input  logic          mmcm_psdone,
  output logic          mmcm_psen,
  output logic          mmcm_psincdec,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] win_start,
  output logic [CW-1:0] win_len,
  output logic [CW-1:0] phase
);
  localparam int NW = $clog2(max2(SETTLE, SAMPLES) + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  state_t state;
  logic [NW-1:0] cnt;
  logic good;
  logic [CW-1:0] run_start, run_len, target, new_len, new_start;
  logic step_req, step_dir, step_ack, step_to, abort;
  assign target    = win_len != '0 ? win_start + (win_len >> 1) : '0;
  assign new_len   = run_len + 1'b1;
  assign new_start = run_len == '0 ? phase : run_start;
  assign step_dir  = state == S_STEP;
  assign step_req  = mmcm_locked & (step_dir | (state == S_CENTER & phase != target));
  assign abort     = state != S_IDLE & ~mmcm_locked;
  ps_stepper #(.TIMEOUT(TIMEOUT)) u_stepper (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .req(step_req),
    .dir(step_dir),
    .psdone(mmcm_psdone),
    .abort(abort),
    .psen(mmcm_psen),
    .psincdec(mmcm_psincdec),
    .ack(step_ack),
    .timeout(step_to)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      good      <= 1'b0;
      run_start <= '0;
      run_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      win_start <= '0;
      win_len   <= '0;
      phase     <= '0;
    end else begin
      done <= 1'b0;
      if (abort || step_to) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
        error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            if (mmcm_locked) begin
              state     <= S_SETTLE;
              busy      <= 1'b1;
              error     <= 1'b0;
              win_start <= '0;
              win_len   <= '0;
              phase     <= '0;
              run_start <= '0;
              run_len   <= '0;
              cnt       <= '0;
            end else begin
              error <= 1'b1;
              done  <= 1'b1;
            end
          end
          S_SETTLE: begin
            cnt <= cnt + 1'b1;
            if (cnt == NW'(SETTLE - 1)) begin
              state <= S_SAMPLE;
              cnt   <= '0;
              good  <= 1'b1;
            end
          end
          S_SAMPLE: begin
            cnt  <= cnt + 1'b1;
            good <= good & data_ok;
            if (cnt == NW'(SAMPLES - 1)) begin
              state <= S_EVAL;
              cnt   <= '0;
            end
          end
          S_EVAL: begin
            // the open run is scored every position, so a run reaching STEPS-1 is closed here too
            run_len   <= good ? new_len : '0;
            run_start <= good ? new_start : run_start;
            if (good && new_len > win_len) begin
              win_len   <= new_len;
              win_start <= new_start;
            end
            state <= phase == LAST ? S_CENTER : S_STEP;
          end
          S_STEP: begin
            phase <= phase + 1'b1;
            state <= S_STEP_WAIT;
          end
          S_STEP_WAIT: if (step_ack) state <= S_SETTLE;
          S_CENTER: begin
            if (win_len == '0) error <= 1'b1;
            if (phase == target) state <= S_FINISH;
            else begin
              phase <= phase - 1'b1;
              state <= S_CENTER_WAIT;
            end
          end
          S_CENTER_WAIT: if (step_ack) state <= S_CENTER;
          S_FINISH: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_phase_cal.sv
// tb_adc_phase_cal: directed scenarios against an MMCM model answering psen after 3 cycles
module tb_adc_phase_cal;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, locked = 1'b1, psdone = 1'b0;
  logic data_ok, psen, psincdec, busy, done, error;
  logic [9:0] win_start, win_len, phase;
  logic [15:0] mask = '1;
  int pos = 0, ninc = 0, ndec = 0, ndone = 0, cd = 0, hold_after = 1000;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign data_ok = mask[pos[3:0]];
  adc_phase_cal #(.STEPS(16), .SETTLE(4), .SAMPLES(8), .TIMEOUT(20), .CW(10)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mmcm_locked(locked), .data_ok(data_ok),
    .mmcm_psdone(psdone), .mmcm_psen(psen), .mmcm_psincdec(psincdec), .busy(busy), .done(done),
    .error(error), .win_start(win_start), .win_len(win_len), .phase(phase)
  );
  // MMCM model: tracks position, returns psdone in the 3rd cycle after psen unless withheld
  always @(negedge clk) begin
    psdone = 1'b0;
    if (done) ndone++;
    if (psen) begin
      if (psincdec) begin pos++; ninc++; end else begin pos--; ndec++; end
      cd = (psincdec && ninc > hold_after) ? 0 : 3;
    end else if (cd > 0) begin
      cd--;
      psdone = (cd == 0);
    end
  end
  task automatic clr(input logic [15:0] m);
    mask = m; pos = 0; ninc = 0; ndec = 0; ndone = 0; hold_after = 1000;
  endtask
  task automatic do_run(input int budget, output bit got, output bit busy_on, output bit busy_at_done);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_on = busy;
    got = 1'b0;
    busy_at_done = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; busy_at_done = busy; end
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error, psen, psincdec} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, done, error, psen, psincdec}); end
    checks++; if ({phase, win_start, win_len} !== 30'd0) begin errors++; $display("FAIL reset_fields got %0d/%0d/%0d exp 0/0/0", phase, win_start, win_len); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_all_good;
    bit got, bon, bdone;
    clr(16'hFFFF);
    do_run(1000, got, bon, bdone);
    repeat (3) @(negedge clk);
    checks++; if (!got) begin errors++; $display("FAIL good_done got none exp pulse"); end
    checks++; if (bon !== 1'b1) begin errors++; $display("FAIL good_busy_rise got %0d exp 1", bon); end
    checks++; if (bdone !== 1'b0) begin errors++; $display("FAIL good_busy_at_done got %0d exp 0", bdone); end
    checks++; if (win_start !== 10'd0 || win_len !== 10'd16) begin errors++; $display("FAIL good_win got %0d/%0d exp 0/16", win_start, win_len); end
    checks++; if (phase !== 10'd8 || error !== 1'b0) begin errors++; $display("FAIL good_phase got %0d err %0d exp 8 err 0", phase, error); end
    checks++; if (ninc != 15 || ndec != 7 || ndone != 1) begin errors++; $display("FAIL good_steps got %0d/%0d/%0d exp 15/7/1", ninc, ndec, ndone); end
  endtask
  task automatic test_mid_window;
    bit got, bon, bdone;
    clr(16'h03E0);
    do_run(1000, got, bon, bdone);
    repeat (3) @(negedge clk);
    checks++; if (!got) begin errors++; $display("FAIL mid_done got none exp pulse"); end
    checks++; if (win_start !== 10'd5 || win_len !== 10'd5) begin errors++; $display("FAIL mid_win got %0d/%0d exp 5/5", win_start, win_len); end
    checks++; if (phase !== 10'd7 || ndec != 8 || error !== 1'b0) begin errors++; $display("FAIL mid_park got %0d/%0d err %0d exp 7/8 err 0", phase, ndec, error); end
  endtask
  task automatic test_two_windows;
    bit got, bon, bdone;
    clr(16'h1C1C);
    do_run(1000, got, bon, bdone);
    repeat (3) @(negedge clk);
    checks++; if (win_start !== 10'd2 || win_len !== 10'd3) begin errors++; $display("FAIL tie_win got %0d/%0d exp 2/3", win_start, win_len); end
    checks++; if (phase !== 10'd3 || ndec != 12) begin errors++; $display("FAIL tie_park got %0d/%0d exp 3/12", phase, ndec); end
    clr(16'hE000);
    do_run(1000, got, bon, bdone);
    repeat (3) @(negedge clk);
    checks++; if (win_start !== 10'd13 || win_len !== 10'd3) begin errors++; $display("FAIL end_win got %0d/%0d exp 13/3", win_start, win_len); end
    checks++; if (phase !== 10'd14 || ndec != 1 || error !== 1'b0) begin errors++; $display("FAIL end_park got %0d/%0d err %0d exp 14/1 err 0", phase, ndec, error); end
  endtask
  task automatic test_all_bad;
    bit got, bon, bdone;
    clr(16'h0000);
    do_run(1000, got, bon, bdone);
    repeat (3) @(negedge clk);
    checks++; if (win_len !== 10'd0 || error !== 1'b1) begin errors++; $display("FAIL bad_result got len %0d err %0d exp 0 1", win_len, error); end
    checks++; if (phase !== 10'd0 || ndec != 15 || ndone != 1) begin errors++; $display("FAIL bad_park got %0d/%0d/%0d exp 0/15/1", phase, ndec, ndone); end
  endtask
  task automatic test_timeout;
    int t = 1, nseen = 0, psen5 = -1, done_t = -1;
    clr(16'hFFFF);
    hold_after = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_t < 0 && t < 1500) begin
      @(negedge clk);
      t++;
      start = (t == 30);
      if (psen) begin nseen++; if (nseen == 5) psen5 = t; end
      if (done) done_t = t;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_t - psen5 != 21 || psen5 < 0) begin errors++; $display("FAIL to_latency got %0d exp 21", done_t - psen5); end
    checks++; if (phase !== 10'd5 || error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_state got ph %0d err %0d busy %0d exp 5 1 0", phase, error, busy); end
    checks++; if (ninc != 5 || ndone != 1) begin errors++; $display("FAIL to_counts got %0d/%0d exp 5/1", ninc, ndone); end
  endtask
  task automatic test_lock_drop;
    clr(16'hFFFF);
    locked = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({done, error, busy} !== 3'b110) begin errors++; $display("FAIL unlocked_start got %b exp 110", {done, error, busy}); end
    @(negedge clk);
    locked = 1'b1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL unlocked_pulse got %0d exp 0", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if ({busy, error} !== 2'b10) begin errors++; $display("FAIL sample_state got %b exp 10", {busy, error}); end
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    checks++; if ({busy, done, error} !== 3'b011 || phase !== 10'd0) begin errors++; $display("FAIL lock_abort got %b ph %0d exp 011 ph 0", {busy, done, error}, phase); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lock_idle got %b exp 00", {done, busy}); end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    clr(16'hFFFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!psen && n < 200) begin @(negedge clk); n++; end
    checks++; if (psen !== 1'b1) begin errors++; $display("FAIL rm_psen got %0d exp 1", psen); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, error, psen, psincdec} !== 5'b0 || {phase, win_start, win_len} !== 30'd0) begin errors++; $display("FAIL rm_outputs got %b ph %0d win %0d/%0d exp 0", {busy, done, error, psen, psincdec}, phase, win_start, win_len); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || phase !== 10'd0 || ninc != 1 || ndone != 0) begin errors++; $display("FAIL rm_late_psdone got busy %0d ph %0d inc %0d done %0d exp 0 0 1 0", busy, phase, ninc, ndone); end
  endtask
  initial begin
    test_reset;
    test_all_good;
    test_mid_window;
    test_two_windows;
    test_all_bad;
    test_timeout;
    test_lock_drop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
